vect_serializer: RTL and testbench



---
 rtl/vect_serializer_pkg.sv | 34 +++
 rtl/vect_elem_mux.sv | 26 ++
 rtl/vect_serializer.sv | 103 ++++++++++
 tb/tb_vect_serializer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/vect_serializer_pkg.sv
// Shared definitions for the vector serializer: vector-block size macros,
// index width, FSM state type and the element-count clamp helper.

`ifndef N_MAX
`define N_MAX 4
`endif

// Index width shared by every consumer of an element index (minimum 1 bit).
`ifndef VECT_IDX_W
`define VECT_IDX_W ((`N_MAX > 1) ? $clog2(`N_MAX) : 1)
`endif

package vect_serializer_pkg;

  localparam int N_MAX = `N_MAX;
  localparam int IDX_W = `VECT_IDX_W;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // Limit a requested element count to the number of elements in a vector.
  function automatic logic [IDX_W:0] clamp_len(input logic [IDX_W:0] n);
    logic [IDX_W:0] res;
    if (n > (IDX_W+1)'(N_MAX)) begin
      res = (IDX_W+1)'(N_MAX);
    end else begin
      res = n;
    end
    return res;
  endfunction

endpackage

// File: rtl/vect_elem_mux.sv
// Purely combinational N_MAX:1 element selector for packed vectors.
// Element i sits at vect[i*WIDTH +: WIDTH]; out-of-range indices give zero.

module vect_elem_mux #(
  parameter int WIDTH = 43,
  parameter int N_MAX = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_MAX*WIDTH-1:0] vect,
  input  logic [IDX_W-1:0]       idx,
  output logic [WIDTH-1:0]       elem
);

  // Select the element addressed by idx.
  always_comb begin
    elem = '0;
    for (int i = 0; i < N_MAX; i++) begin
      if (idx == IDX_W'(i)) begin
        elem = vect[i*WIDTH +: WIDTH];
      end else begin
        elem = elem;
      end
    end
  end

endmodule

// File: rtl/vect_serializer.sv
// Packed vector to scalar stream converter. Accepts one packed vector per
// transaction and emits its first n elements one per handshake, with index
// and last flag. Elements pass through bit-exact.

module vect_serializer
  import vect_serializer_pkg::*;
#(
  parameter int WIDTH = 43,
  parameter int FRAC  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_MAX*WIDTH-1:0] vect_in,
  input  logic [IDX_W:0]         n_elem,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
  output logic                   busy
);

  // The fractional width only documents the element format; nothing is computed from it.
  logic unused_frac;
  assign unused_frac = (FRAC > WIDTH);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W:0]         n_q, n_d;
  logic [N_MAX*WIDTH-1:0] buf_q, buf_d;

  logic           accept_s;
  logic           beat_s;
  logic [IDX_W:0] last_idx_s;

  // Element selection from the held buffer; out_ready never reaches this path.
  vect_elem_mux #(
    .WIDTH (WIDTH),
    .N_MAX (N_MAX),
    .IDX_W (IDX_W)
  ) u_elem_mux (
    .vect (buf_q),
    .idx  (idx_q),
    .elem (out_data)
  );

  // Output flags and handshakes derived from the registered state.
  always_comb begin
    last_idx_s = n_q - (IDX_W+1)'(1);
    out_valid  = (state_q == ST_STREAM);
    busy       = (state_q == ST_STREAM);
    out_idx    = idx_q;
    out_last   = (state_q == ST_STREAM) && ({1'b0, idx_q} == last_idx_s);
    beat_s     = out_valid && out_ready;
    in_ready   = (state_q == ST_IDLE) || (out_valid && out_last && out_ready);
    accept_s   = in_valid && in_ready;
  end

  // Next-state logic: accept reloads everything, a beat advances or finishes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    buf_d   = buf_q;
    if (accept_s) begin
      buf_d = vect_in;
      n_d   = clamp_len(n_elem);
      idx_d = '0;
      if (clamp_len(n_elem) != '0) begin
        state_d = ST_STREAM;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (beat_s) begin
      if (out_last) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      state_d = state_q;
    end
  end

  // State, counter and buffer registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_vect_serializer.sv
// Self-checking bench for vect_serializer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.

module tb_vect_serializer;
  import vect_serializer_pkg::*;

  localparam int WIDTH = 43;
  localparam int FRAC  = 32;
  localparam int VW    = N_MAX * WIDTH;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [VW-1:0]        vect_in;
  logic [IDX_W:0]       n_elem;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_last;
  logic                 busy;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               idx;
    logic             last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks;
  int    n_fail;
  logic  last_acc;

  vect_serializer #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vect_in   (vect_in),
    .n_elem    (n_elem),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs on the falling edge, compare outputs against the
  // model, then advance the model as the rising edge will.
  task automatic step(input logic iv, input logic [VW-1:0] v, input logic [IDX_W:0] ne,
                      input logic ordy);
    logic exp_valid;
    logic exp_rdy;
    int   n;
    beat_t b;
    @(negedge clk);
    in_valid  = iv;
    vect_in   = v;
    n_elem    = ne;
    out_ready = ordy;
    #1;
    exp_valid = (exp_q.size() > 0);
    exp_rdy   = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    check("busy", 64'(busy), 64'(exp_valid));
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (exp_valid) begin
      check("out_data", 64'(out_data), 64'(exp_q[0].data));
      check("out_idx", 64'(out_idx), 64'(exp_q[0].idx));
      check("out_last", 64'(out_last), 64'(exp_q[0].last));
    end else begin
      check("out_last_idle", 64'(out_last), 64'd0);
    end
    if (exp_valid && ordy) begin
      void'(exp_q.pop_front());
    end
    last_acc = iv && exp_rdy;
    if (last_acc) begin
      n = (int'(ne) > N_MAX) ? N_MAX : int'(ne);
      for (int k = 0; k < n; k++) begin
        b.data = v[k*WIDTH +: WIDTH];
        b.idx  = k;
        b.last = (k == n - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < N_MAX; k++) begin
      v[k*WIDTH +: WIDTH] = WIDTH'({$urandom(), $urandom()});
    end
    return v;
  endfunction

  logic [VW-1:0]    vec_a;
  logic [VW-1:0]    vec_b;
  logic [VW-1:0]    p_vec;
  logic [IDX_W:0]   p_n;
  logic             p_valid;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    vect_in   = '0;
    n_elem    = '0;
    out_ready = 1'b0;
    vec_a     = {43'h003_0000_0000, 43'h000_4000_0000, 43'h7FD_8000_0000, 43'h001_0000_0000};
    vec_b     = rand_vec();

    // Reset values, with an offer present that must not be taken.
    @(negedge clk);
    in_valid = 1'b1;
    vect_in  = vec_a;
    n_elem   = (IDX_W+1)'(4);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;

    // Full vector with the consumer always ready.
    step(1'b1, vec_a, (IDX_W+1)'(4), 1'b1);
    for (int c = 0; c < 5; c++) step(1'b0, '0, '0, 1'b1);

    // Backpressure on idx 1 for three cycles.
    step(1'b1, vec_a, (IDX_W+1)'(4), 1'b1);
    step(1'b0, '0, '0, 1'b1);
    for (int c = 0; c < 3; c++) step(1'b0, '0, '0, 1'b0);
    for (int c = 0; c < 4; c++) step(1'b0, '0, '0, 1'b1);

    // Length handling: 2, 0 and 7 (clamped).
    step(1'b1, vec_b, (IDX_W+1)'(2), 1'b1);
    for (int c = 0; c < 3; c++) step(1'b0, '0, '0, 1'b1);
    step(1'b1, vec_b, (IDX_W+1)'(0), 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b1, vec_b, (IDX_W+1)'(7), 1'b1);
    for (int c = 0; c < 5; c++) step(1'b0, '0, '0, 1'b1);

    // Back-to-back with B held from the first beat of A (stalled until last beat).
    step(1'b1, vec_a, (IDX_W+1)'(3), 1'b1);
    for (int c = 0; c < 3; c++) step(1'b1, vec_b, (IDX_W+1)'(4), 1'b1);
    check("b2b_accept_on_last", 64'(last_acc), 64'd1);
    for (int c = 0; c < 5; c++) step(1'b0, '0, '0, 1'b1);

    // Mid-stream reset while idx 2 is presented.
    step(1'b1, vec_a, (IDX_W+1)'(4), 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("pre_rst_idx", 64'(out_idx), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, vec_b, (IDX_W+1)'(4), 1'b1);
    for (int c = 0; c < 5; c++) step(1'b0, '0, '0, 1'b1);

    // Randomized traffic; an unaccepted offer is held unchanged.
    p_valid = 1'b0;
    p_vec   = '0;
    p_n     = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!p_valid && ($urandom_range(0, 2) != 0)) begin
        p_valid = 1'b1;
        p_vec   = rand_vec();
        p_n     = (IDX_W+1)'($urandom_range(0, 2**(IDX_W+1) - 1));
      end
      step(p_valid, p_vec, p_n, ($urandom_range(0, 3) != 0));
      if (last_acc) p_valid = 1'b0;
    end
    for (int c = 0; c < 8; c++) step(1'b0, '0, '0, 1'b1);
    check("drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
